axba_line_decompressor: RTL and testbench

AXBA_LINE_DECOMPRESSOR -- requirements
Module: axba_line_decompressor

---
 rtl/axba_pkg.sv | 20 ++
 rtl/axba_word_expand.sv | 33 +++
 rtl/axba_line_decompressor.sv | 127 ++++++++++++
 tb/tb_axba_line_decompressor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axba_pkg.sv
// Shared types and default geometry for the AXBA line decompressor.
package axba_pkg;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      MID  = 2'd1,
      ONES = 2'd2
   } fill_mode_e;

   typedef enum logic {
      COLLECT = 1'b0,
      DELIVER = 1'b1
   } dec_state_e;

   localparam int AXBA_W     = 32;
   localparam int AXBA_DROP  = 8;
   localparam int AXBA_LANES = 8;
   localparam int AXBA_BEATS = 1;

endpackage

// File: rtl/axba_word_expand.sv
// Rebuilds one W-bit word from a truncated compressed word by appending DROP fill bits.
module axba_word_expand
   import axba_pkg::*;
#(
   parameter int W    = AXBA_W,
   parameter int DROP = AXBA_DROP
) (
   input  logic [W-DROP-1:0] cw,
   input  logic [1:0]        mode,
   output logic [W-1:0]      word
);

   generate
      if (DROP == 0) begin : g_passthru
         logic unused_mode;
         assign unused_mode = ^mode;
         assign word        = cw;
      end else begin : g_fill
         logic [DROP-1:0] fill;
         // Reserved encoding 3 falls into the default arm and fills with zeros.
         always_comb begin
            fill = '0;
            case (fill_mode_e'(mode))
               MID:     fill[DROP-1] = 1'b1;
               ONES:    fill = '1;
               default: fill = '0;
            endcase
         end
         assign word = {cw, fill};
      end
   endgenerate

endmodule

// File: rtl/axba_line_decompressor.sv
// Collects BEATS compressed beats into one reconstructed line and hands it off.
// Optional lane parity checking is enabled with `define AXBA_DECOMP_PARITY_EN.
module axba_line_decompressor
   import axba_pkg::*;
#(
   parameter int W     = AXBA_W,
   parameter int DROP  = AXBA_DROP,
   parameter int LANES = AXBA_LANES,
   parameter int BEATS = AXBA_BEATS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [LANES*(W-DROP)-1:0]   in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [1:0]                  fill_mode,
   output logic [LANES*BEATS*W-1:0]    out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
`ifdef AXBA_DECOMP_PARITY_EN
   input  logic [LANES-1:0]            in_parity,
   output logic                        parity_err,
`endif
   output logic [15:0]                 lines_done
);

   localparam int CW = W - DROP;
   localparam int N  = LANES * BEATS;
   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   dec_state_e         state_q, state_d;
   logic [BW-1:0]      beat_q, beat_d;
   logic [1:0]         mode_q, mode_d;
   logic [N*W-1:0]     line_q, line_d;
   logic [15:0]        done_q, done_d;
   logic [1:0]         eff_mode;
   logic [LANES*W-1:0] beat_words;
   logic               beat_acc;

   assign beat_acc = in_valid && (state_q == COLLECT);
   // Beat 0 expands with the live mode; later beats reuse the mode captured with beat 0.
   assign eff_mode = (beat_q == '0) ? fill_mode : mode_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      axba_word_expand #(.W(W), .DROP(DROP)) u_expand (
         .cw   (in_data[i*CW +: CW]),
         .mode (eff_mode),
         .word (beat_words[i*W +: W])
      );
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      mode_d  = mode_q;
      line_d  = line_q;
      done_d  = done_q;
      case (state_q)
         COLLECT: begin
            if (in_valid) begin
               if (beat_q == '0) mode_d = fill_mode;
               for (int b = 0; b < BEATS; b++) begin
                  if (beat_q == BW'(b)) line_d[b*LANES*W +: LANES*W] = beat_words;
               end
               if (beat_q == BW'(BEATS-1)) begin
                  beat_d  = '0;
                  state_d = DELIVER;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         DELIVER: begin
            if (out_ready) begin
               state_d = COLLECT;
               done_d  = done_q + 16'd1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= COLLECT;
         beat_q  <= '0;
         mode_q  <= ZERO;
         line_q  <= '0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         mode_q  <= mode_d;
         line_q  <= line_d;
         done_q  <= done_d;
      end
   end

   assign in_ready   = (state_q == COLLECT);
   assign out_valid  = (state_q == DELIVER);
   assign out_data   = line_q;
   assign lines_done = done_q;

`ifdef AXBA_DECOMP_PARITY_EN
   logic             perr_q, perr_d;
   logic [LANES-1:0] lane_bad;

   always_comb begin
      lane_bad = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_bad[i] = (^in_data[i*CW +: CW]) ^ in_parity[i];
      end
      perr_d = perr_q || (beat_acc && (|lane_bad));
   end

   always_ff @(posedge clk) begin
      if (reset) perr_q <= 1'b0;
      else       perr_q <= perr_d;
   end

   assign parity_err = perr_q;
`else
   logic unused_acc;
   assign unused_acc = beat_acc;
`endif

endmodule

// File: tb/tb_axba_line_decompressor.sv
// Self-checking bench: three decompressor geometries, directed scenarios plus a random lockstep model.
module tb_axba_line_decompressor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   int   checks   = 0;
   int   failures = 0;

   // A: defaults (W32 DROP8 LANES8 BEATS1)
   logic [191:0]  a_in_data;
   logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [1:0]    a_mode;
   logic [255:0]  a_out_data;
   logic [15:0]   a_done;
   // B: four beats per line
   logic [191:0]  b_in_data;
   logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [1:0]    b_mode;
   logic [1023:0] b_out_data;
   logic [15:0]   b_done;
   // C: no dropped bits (W8 DROP0 LANES2 BEATS2)
   logic [15:0]   c_in_data;
   logic          c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   logic [1:0]    c_mode;
   logic [31:0]   c_out_data;
   logic [15:0]   c_done;
`ifdef AXBA_DECOMP_PARITY_EN
   logic [7:0]    a_par, b_par;
   logic [1:0]    c_par;
   logic          a_perr, b_perr, c_perr;
`endif

   axba_line_decompressor dut_a (
      .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .fill_mode(a_mode), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef AXBA_DECOMP_PARITY_EN
      .in_parity(a_par), .parity_err(a_perr),
`endif
      .lines_done(a_done));

   axba_line_decompressor #(.W(32), .DROP(8), .LANES(8), .BEATS(4)) dut_b (
      .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .fill_mode(b_mode), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef AXBA_DECOMP_PARITY_EN
      .in_parity(b_par), .parity_err(b_perr),
`endif
      .lines_done(b_done));

   axba_line_decompressor #(.W(8), .DROP(0), .LANES(2), .BEATS(2)) dut_c (
      .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .fill_mode(c_mode), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
`ifdef AXBA_DECOMP_PARITY_EN
      .in_parity(c_par), .parity_err(c_perr),
`endif
      .lines_done(c_done));

   // word = cw * 2^drop + fill
   function automatic logic [63:0] expand(input logic [63:0] cw, input int mode, input int drop);
      logic [63:0] fill;
      if (drop == 0) return cw;
      case (mode)
         1:       fill = 64'd1 << (drop - 1);
         2:       fill = (64'd1 << drop) - 64'd1;
         default: fill = 64'd0;
      endcase
      return cw * (64'd1 << drop) + fill;
   endfunction

   function automatic logic [255:0] exp_beat(input logic [191:0] d, input int mode);
      logic [255:0] r;
      logic [63:0]  lane;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         lane = 64'(d[i*24 +: 24]);
         r[i*32 +: 32] = 32'(expand(lane, mode, 8));
      end
      return r;
   endfunction

   function automatic logic [191:0] rand192();
      logic [191:0] r;
      for (int j = 0; j < 6; j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

`ifdef AXBA_DECOMP_PARITY_EN
   function automatic logic [7:0] lane_par(input logic [191:0] d, input int lanes, input int cw);
      logic [7:0] p;
      p = '0;
      for (int i = 0; i < lanes; i++)
         for (int k = 0; k < cw; k++) p[i] = p[i] ^ d[i*cw + k];
      return p;
   endfunction
`endif

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Presents one beat for a single clock, returns at the following negedge.
   task automatic drive_beat(input int sel, input logic [191:0] d, input logic [1:0] m);
`ifdef AXBA_DECOMP_PARITY_EN
      logic [7:0] p;
`endif
      case (sel)
         0: begin
            a_in_data = d; a_mode = m; a_in_valid = 1'b1;
`ifdef AXBA_DECOMP_PARITY_EN
            a_par = lane_par(d, 8, 24);
`endif
         end
         1: begin
            b_in_data = d; b_mode = m; b_in_valid = 1'b1;
`ifdef AXBA_DECOMP_PARITY_EN
            b_par = lane_par(d, 8, 24);
`endif
         end
         default: begin
            c_in_data = d[15:0]; c_mode = m; c_in_valid = 1'b1;
`ifdef AXBA_DECOMP_PARITY_EN
            p = lane_par(d, 2, 8);
            c_par = p[1:0];
`endif
         end
      endcase
      @(negedge clk);
      a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_a_hs got rdy=%b vld=%b exp rdy=1 vld=0", a_in_ready, a_out_valid); end
      checks++; if (a_out_data !== '0 || a_done !== 16'd0) begin failures++; $display("FAIL rst_a_data got done=%0d data=%h exp 0", a_done, a_out_data); end
      checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_done !== 16'd0) begin failures++; $display("FAIL rst_b got rdy=%b vld=%b done=%0d", b_in_ready, b_out_valid, b_done); end
      checks++; if (c_in_ready !== 1'b1 || c_out_valid !== 1'b0 || c_out_data !== '0) begin failures++; $display("FAIL rst_c got rdy=%b vld=%b data=%h", c_in_ready, c_out_valid, c_out_data); end
      a_out_ready = 1'b0;
      drive_beat(0, rand192(), 2'd1);
      checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL rst_hold_valid got=%b exp=1", a_out_valid); end
      do_reset();
      checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL rst_drop_hs got vld=%b rdy=%b exp vld=0 rdy=1", a_out_valid, a_in_ready); end
      checks++; if (a_out_data !== '0 || a_done !== 16'd0) begin failures++; $display("FAIL rst_drop_data got done=%0d data=%h exp 0", a_done, a_out_data); end
   endtask

   task automatic test_basic();
      logic [191:0] d;
      logic [31:0]  w;
      do_reset();
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) d[i*24 +: 24] = 24'(1 + i);
      drive_beat(0, d, 2'd0);
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin failures++; $display("FAIL basic_hs got vld=%b rdy=%b exp vld=1 rdy=0", a_out_valid, a_in_ready); end
      for (int i = 0; i < 8; i++) begin
         w = 32'h00000100 + 32'(i << 8);
         checks++; if (a_out_data[i*32 +: 32] !== w) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, a_out_data[i*32 +: 32], w); end
      end
      @(negedge clk);
      checks++; if (a_done !== 16'd1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin failures++; $display("FAIL basic_handoff got done=%0d vld=%b rdy=%b exp 1/0/1", a_done, a_out_valid, a_in_ready); end
   endtask

   task automatic test_modes();
      logic [191:0] d;
      logic [31:0]  exp_w [4];
      exp_w[0] = 32'hABCDEF00; exp_w[1] = 32'hABCDEF80; exp_w[2] = 32'hABCDEFFF; exp_w[3] = 32'hABCDEF00;
      do_reset();
      a_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) d[i*24 +: 24] = 24'hABCDEF;
      for (int m = 0; m < 4; m++) begin
         drive_beat(0, d, 2'(m));
         for (int i = 0; i < 8; i++) begin
            checks++; if (a_out_data[i*32 +: 32] !== exp_w[m]) begin failures++; $display("FAIL mode%0d_word%0d got=%h exp=%h", m, i, a_out_data[i*32 +: 32], exp_w[m]); end
         end
         @(negedge clk);
      end
      checks++; if (a_done !== 16'd4) begin failures++; $display("FAIL modes_done got=%0d exp=4", a_done); end
   endtask

   task automatic test_stall();
      logic [191:0] d1, d2;
      logic [1:0]   m1, m2;
      logic [255:0] e1;
      do_reset();
      a_out_ready = 1'b0;
      d1 = rand192(); m1 = 2'($urandom_range(0, 3));
      e1 = exp_beat(d1, int'(m1));
      drive_beat(0, d1, m1);
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== e1) begin failures++; $display("FAIL stall_first got vld=%b data=%h exp data=%h", a_out_valid, a_out_data, e1); end
      for (int c = 0; c < 5; c++) begin
         a_in_data = rand192(); a_mode = 2'($urandom_range(0, 3)); a_in_valid = 1'b1;
`ifdef AXBA_DECOMP_PARITY_EN
         a_par = lane_par(a_in_data, 8, 24);
`endif
         @(negedge clk);
         checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_done !== 16'd0) begin failures++; $display("FAIL stall_hs%0d got rdy=%b vld=%b done=%0d exp 0/1/0", c, a_in_ready, a_out_valid, a_done); end
         checks++; if (a_out_data !== e1) begin failures++; $display("FAIL stall_data%0d got=%h exp=%h", c, a_out_data, e1); end
      end
      d2 = rand192(); m2 = 2'($urandom_range(0, 3));
      a_in_data = d2; a_mode = m2; a_in_valid = 1'b1; a_out_ready = 1'b1;
`ifdef AXBA_DECOMP_PARITY_EN
      a_par = lane_par(d2, 8, 24);
`endif
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_done !== 16'd1) begin failures++; $display("FAIL stall_release got vld=%b rdy=%b done=%0d exp 0/1/1", a_out_valid, a_in_ready, a_done); end
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp_beat(d2, int'(m2))) begin failures++; $display("FAIL stall_next got vld=%b data=%h exp=%h", a_out_valid, a_out_data, exp_beat(d2, int'(m2))); end
      @(negedge clk);
      checks++; if (a_done !== 16'd2) begin failures++; $display("FAIL stall_done got=%0d exp=2", a_done); end
   endtask

   task automatic test_gaps_mode();
      logic [191:0]  d;
      logic [1:0]    m0, mo;
      logic [1023:0] e;
      int            gaps;
      do_reset();
      b_out_ready = 1'b0;
      m0 = 2'($urandom_range(0, 3));
      mo = (m0 == 2'd2) ? 2'd1 : 2'd2;
      for (int b = 0; b < 4; b++) begin
         gaps = 1 + $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            b_in_valid = 1'b0; b_mode = 2'($urandom_range(0, 3));
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL gap_b%0d_vld got=%b exp=0", b, b_out_valid); end
         end
         d = rand192();
         e[b*256 +: 256] = exp_beat(d, int'(m0));
         drive_beat(1, d, (b == 0) ? m0 : mo);
         checks++; if (b_out_valid !== (b == 3)) begin failures++; $display("FAIL beat%0d_vld got=%b exp=%b", b, b_out_valid, (b == 3)); end
      end
      checks++; if (b_out_data !== e) begin failures++; $display("FAIL gaps_line got=%h exp=%h", b_out_data, e); end
      b_out_ready = 1'b1;
      @(negedge clk);
      checks++; if (b_done !== 16'd1 || b_in_ready !== 1'b1) begin failures++; $display("FAIL gaps_handoff got done=%0d rdy=%b exp 1/1", b_done, b_in_ready); end
   endtask

   task automatic test_reset_midline();
      logic [191:0]  d;
      logic [1:0]    m;
      logic [1023:0] e;
      do_reset();
      b_out_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         drive_beat(1, rand192(), 2'($urandom_range(0, 3)));
         checks++; if (b_out_valid !== 1'b0) begin failures++; $display("FAIL mid_beat%0d_vld got=%b exp=0", b, b_out_valid); end
      end
      do_reset();
      checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_data !== '0 || b_done !== 16'd0) begin failures++; $display("FAIL mid_reset got vld=%b rdy=%b done=%0d", b_out_valid, b_in_ready, b_done); end
      m = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) begin
         d = rand192();
         e[b*256 +: 256] = exp_beat(d, int'(m));
         drive_beat(1, d, (b == 0) ? m : 2'($urandom_range(0, 3)));
      end
      checks++; if (b_out_valid !== 1'b1 || b_out_data !== e) begin failures++; $display("FAIL mid_newline got vld=%b data=%h exp=%h", b_out_valid, b_out_data, e); end
      @(negedge clk);
      checks++; if (b_done !== 16'd1) begin failures++; $display("FAIL mid_done got=%0d exp=1", b_done); end
   endtask

`ifdef AXBA_DECOMP_PARITY_EN
   task automatic test_parity();
      logic [191:0] d;
      logic [7:0]   p;
      int           lane;
      do_reset();
      a_out_ready = 1'b1;
      drive_beat(0, rand192(), 2'd0);
      checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL par_clean got=%b exp=0", a_perr); end
      @(negedge clk);
      d = rand192(); lane = $urandom_range(0, 7);
      p = lane_par(d, 8, 24); p[lane] = ~p[lane];
      a_in_data = d; a_mode = 2'd0; a_par = p; a_in_valid = 1'b1;
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++; if (a_perr !== 1'b1) begin failures++; $display("FAIL par_set got=%b exp=1", a_perr); end
      checks++; if (a_out_data !== exp_beat(d, 0)) begin failures++; $display("FAIL par_data got=%h exp=%h", a_out_data, exp_beat(d, 0)); end
      @(negedge clk);
      drive_beat(0, rand192(), 2'd1);
      @(negedge clk);
      checks++; if (a_perr !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b exp=1", a_perr); end
      do_reset();
      checks++; if (a_perr !== 1'b0) begin failures++; $display("FAIL par_reset got=%b exp=0", a_perr); end
   endtask
`endif

   // Cycle-by-cycle random traffic against an abstract line model (sel 1 = B, otherwise C).
   task automatic test_random(input int sel, input int cycles);
      int            w, drop, lanes, beats, cw, beat, mode_m, done;
      bit            full, iv, ordy;
      logic [1:0]    md;
      logic [63:0]   words [32];
      logic [63:0]   lane;
      logic [191:0]  in_v;
      logic [1023:0] exp_line, got_line;
      logic          g_rdy, g_vld;
      logic [15:0]   g_done;
`ifdef AXBA_DECOMP_PARITY_EN
      logic [7:0]    p;
`endif
      if (sel == 1) begin w = 32; drop = 8; lanes = 8; beats = 4; end
      else          begin w = 8;  drop = 0; lanes = 2; beats = 2; end
      cw = w - drop;
      full = 1'b0; beat = 0; mode_m = 0; done = 0;
      for (int j = 0; j < 32; j++) words[j] = '0;
      do_reset();
      for (int c = 0; c < cycles; c++) begin
         if (sel == 1) begin g_rdy = b_in_ready; g_vld = b_out_valid; g_done = b_done; got_line = b_out_data; end
         else          begin g_rdy = c_in_ready; g_vld = c_out_valid; g_done = c_done; got_line = 1024'(c_out_data); end
         checks++; if (g_rdy !== !full || g_vld !== full) begin failures++; $display("FAIL rnd%0d_hs cyc=%0d got rdy=%b vld=%b exp rdy=%b vld=%b", sel, c, g_rdy, g_vld, !full, full); end
         checks++; if (g_done !== 16'(done)) begin failures++; $display("FAIL rnd%0d_done cyc=%0d got=%0d exp=%0d", sel, c, g_done, done); end
         if (full) begin
            exp_line = '0;
            for (int j = 0; j < lanes * beats; j++)
               for (int k = 0; k < w; k++) exp_line[j*w + k] = words[j][k];
            checks++; if (got_line !== exp_line) begin failures++; $display("FAIL rnd%0d_line cyc=%0d got=%h exp=%h", sel, c, got_line, exp_line); end
         end
         iv = ($urandom_range(0, 2) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         md = 2'($urandom_range(0, 3));
         in_v = rand192();
         if (sel == 1) begin
            b_in_data = in_v; b_in_valid = iv; b_out_ready = ordy; b_mode = md;
`ifdef AXBA_DECOMP_PARITY_EN
            b_par = lane_par(in_v, 8, 24);
`endif
         end else begin
            c_in_data = in_v[15:0]; c_in_valid = iv; c_out_ready = ordy; c_mode = md;
`ifdef AXBA_DECOMP_PARITY_EN
            p = lane_par(in_v, 2, 8);
            c_par = p[1:0];
`endif
         end
         if (full) begin
            if (ordy) begin full = 1'b0; done = (done + 1) % 65536; end
         end else if (iv) begin
            if (beat == 0) mode_m = int'(md);
            for (int i = 0; i < lanes; i++) begin
               lane = '0;
               for (int k = 0; k < cw; k++) lane[k] = in_v[i*cw + k];
               words[beat*lanes + i] = expand(lane, mode_m, drop);
            end
            beat++;
            if (beat == beats) begin beat = 0; full = 1'b1; end
         end
         @(negedge clk);
      end
      b_in_valid = 1'b0; c_in_valid = 1'b0;
`ifdef AXBA_DECOMP_PARITY_EN
      checks++; if (b_perr !== 1'b0 || c_perr !== 1'b0) begin failures++; $display("FAIL rnd%0d_perr got b=%b c=%b exp 0", sel, b_perr, c_perr); end
`endif
   endtask

   initial begin
      reset = 1'b0;
      a_in_data = '0; a_in_valid = 1'b0; a_mode = 2'd0; a_out_ready = 1'b1;
      b_in_data = '0; b_in_valid = 1'b0; b_mode = 2'd0; b_out_ready = 1'b1;
      c_in_data = '0; c_in_valid = 1'b0; c_mode = 2'd0; c_out_ready = 1'b1;
`ifdef AXBA_DECOMP_PARITY_EN
      a_par = '0; b_par = '0; c_par = '0;
`endif
      test_reset();
      test_basic();
      test_modes();
      test_stall();
      test_gaps_mode();
      test_reset_midline();
`ifdef AXBA_DECOMP_PARITY_EN
      test_parity();
`endif
      test_random(1, 400);
      test_random(2, 300);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
